// File: rtl/mcdf_formatter_p.sv
// mcdf_formatter_p: packet formatter for the MCDF data path.
// Collects words for one channel at a time into a local packet buffer,
// requests the downstream bus once a packet is complete (or flushed early)
// and streams it out with start/end framing, channel id and length.
module mcdf_formatter_p #(
  parameter int DW     = 32,
  parameter int CHN    = 4,
  parameter int IDW    = 2,
  parameter int MAXLEN = 32,
  parameter int LW     = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           a2f_val_i,
  input  logic [IDW-1:0] a2f_id_i,
  input  logic [DW-1:0]  a2f_data_i,
  input  logic [2:0]     a2f_pkglen_sel_i,
  input  logic           a2f_end_i,
  output logic           f2a_ack_o,
  output logic           fmt_req_o,
  input  logic           fmt_grant_i,
  output logic [IDW-1:0] fmt_child_o,
  output logic [LW-1:0]  fmt_length_o,
  output logic [DW-1:0]  fmt_data_o,
  output logic           fmt_start_o,
  output logic           fmt_end_o
);

  // Buffer address width; the buffer holds exactly one maximum-length packet.
  localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    REQ  = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] pkt_id;
  logic [IDW-1:0] pkt_id_next;
  logic [LW-1:0]  pkt_len;
  logic [LW-1:0]  pkt_len_next;
  logic [LW-1:0]  count;
  logic [LW-1:0]  count_next;
  logic [LW-1:0]  rd_idx;
  logic [LW-1:0]  sel_len;
  logic           id_ok;
  logic           xfer;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;

  logic [DW-1:0]  mem [MAXLEN];

  // Length select decode: 4 << sel for 0..3, MAXLEN otherwise, never above MAXLEN.
  function automatic logic [LW-1:0] decode_len(input logic [2:0] sel);
    int len;
    len = sel[2] ? MAXLEN : (4 << sel[1:0]);
    if (len > MAXLEN) begin
      len = MAXLEN;
    end
    return LW'(len);
  endfunction

  // Input handshake: open in IDLE for any existing channel, in FILL only for
  // the channel that owns the packet and only while there is room left.
  always_comb begin
    id_ok     = (int'(a2f_id_i) < CHN);
    f2a_ack_o = 1'b0;
    case (state)
      IDLE:    f2a_ack_o = id_ok;
      FILL:    f2a_ack_o = (a2f_id_i == pkt_id) && (count < pkt_len);
      default: f2a_ack_o = 1'b0;
    endcase
  end

  assign xfer    = a2f_val_i && f2a_ack_o;
  assign sel_len = decode_len(a2f_pkglen_sel_i);
  assign wr_addr = count[AW-1:0];

  // Next-state logic: packet capture, early flush, bus request and drain.
  always_comb begin
    state_next   = state;
    pkt_id_next  = pkt_id;
    pkt_len_next = pkt_len;
    count_next   = count;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          wr_en        = 1'b1;
          pkt_id_next  = a2f_id_i;
          pkt_len_next = sel_len;
          count_next   = LW'(1);
          if (sel_len == LW'(1)) begin
            state_next = REQ;
          end else if (a2f_end_i) begin
            // First word arrives together with a flush: one-word packet.
            pkt_len_next = LW'(1);
            state_next   = REQ;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (xfer) begin
          wr_en      = 1'b1;
          count_next = count + LW'(1);
        end
        if (count_next == pkt_len) begin
          state_next = REQ;
        end else if (a2f_end_i) begin
          // Flush: the packet shrinks to what has been collected so far.
          pkt_len_next = count_next;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (fmt_grant_i) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (rd_idx == pkt_len) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pkt_id  <= '0;
      pkt_len <= '0;
      count   <= '0;
    end else begin
      state   <= state_next;
      pkt_id  <= pkt_id_next;
      pkt_len <= pkt_len_next;
      count   <= count_next;
    end
  end

  // Packet buffer write port; the buffer itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= a2f_data_i;
    end
  end

  // Registered bus outputs; fmt_data_o doubles as the buffer read register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fmt_req_o    <= 1'b0;
      fmt_child_o  <= '0;
      fmt_length_o <= '0;
      fmt_data_o   <= '0;
      fmt_start_o  <= 1'b0;
      fmt_end_o    <= 1'b0;
      rd_idx       <= '0;
    end else begin
      fmt_req_o <= (state_next == REQ);
      if ((state_next == REQ) || (state_next == SEND)) begin
        fmt_child_o  <= pkt_id_next;
        fmt_length_o <= pkt_len_next;
      end else begin
        fmt_child_o  <= '0;
        fmt_length_o <= '0;
      end
      if ((state == REQ) && fmt_grant_i) begin
        fmt_data_o  <= mem[0];
        fmt_start_o <= 1'b1;
        fmt_end_o   <= (pkt_len == LW'(1));
        rd_idx      <= LW'(1);
      end else if ((state == SEND) && (rd_idx != pkt_len)) begin
        fmt_data_o  <= mem[rd_idx[AW-1:0]];
        fmt_start_o <= 1'b0;
        fmt_end_o   <= (rd_idx == (pkt_len - LW'(1)));
        rd_idx      <= rd_idx + LW'(1);
      end else begin
        fmt_data_o  <= '0;
        fmt_start_o <= 1'b0;
        fmt_end_o   <= 1'b0;
        rd_idx      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mcdf_formatter_p.sv
// tb_mcdf_formatter_p: directed test of the packet formatter with default parameters.
module tb_mcdf_formatter_p;

  logic        clk_i;
  logic        rst_i;
  logic        a2f_val_i;
  logic [1:0]  a2f_id_i;
  logic [31:0] a2f_data_i;
  logic [2:0]  a2f_pkglen_sel_i;
  logic        a2f_end_i;
  logic        f2a_ack_o;
  logic        fmt_req_o;
  logic        fmt_grant_i;
  logic [1:0]  fmt_child_o;
  logic [5:0]  fmt_length_o;
  logic [31:0] fmt_data_o;
  logic        fmt_start_o;
  logic        fmt_end_o;

  int checks;
  int failures;
  int wr_n;
  logic [31:0] exp_words [0:31];

  mcdf_formatter_p dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .a2f_val_i        (a2f_val_i),
    .a2f_id_i         (a2f_id_i),
    .a2f_data_i       (a2f_data_i),
    .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
    .a2f_end_i        (a2f_end_i),
    .f2a_ack_o        (f2a_ack_o),
    .fmt_req_o        (fmt_req_o),
    .fmt_grant_i      (fmt_grant_i),
    .fmt_child_o      (fmt_child_o),
    .fmt_length_o     (fmt_length_o),
    .fmt_data_o       (fmt_data_o),
    .fmt_start_o      (fmt_start_o),
    .fmt_end_o        (fmt_end_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req"},   32'(fmt_req_o),    32'd0);
    chk({tag, "_start"}, 32'(fmt_start_o),  32'd0);
    chk({tag, "_end"},   32'(fmt_end_o),    32'd0);
    chk({tag, "_data"},  fmt_data_o,        32'd0);
    chk({tag, "_child"}, 32'(fmt_child_o),  32'd0);
    chk({tag, "_len"},   32'(fmt_length_o), 32'd0);
  endtask

  // Present one word for one cycle; it must be accepted.
  task automatic put_word(input logic [1:0] id, input logic [31:0] d,
                          input logic [2:0] sel, input logic e);
    a2f_val_i        = 1'b1;
    a2f_id_i         = id;
    a2f_data_i       = d;
    a2f_pkglen_sel_i = sel;
    a2f_end_i        = e;
    #1;
    chk("ack_on_word", 32'(f2a_ack_o), 32'd1);
    exp_words[wr_n] = d;
    wr_n++;
    step();
    a2f_val_i = 1'b0;
    a2f_end_i = 1'b0;
  endtask

  // In REQ: wait gap cycles, hold grant for hold cycles, then check every word.
  task automatic check_packet(input int id, input int len, input int hold, input int gap);
    chk("req_high",   32'(fmt_req_o),    32'd1);
    chk("req_child",  32'(fmt_child_o),  32'(id));
    chk("req_length", 32'(fmt_length_o), 32'(len));
    chk("req_ack",    32'(f2a_ack_o),    32'd0);
    for (int g = 0; g < gap; g++) begin
      step();
      chk("req_wait", 32'(fmt_req_o), 32'd1);
    end
    fmt_grant_i = 1'b1;
    for (int j = 0; j < len; j++) begin
      step();
      if (j == hold - 1) fmt_grant_i = 1'b0;
      $display("tb: pkt id=%0d word %0d data=%h start=%0d end=%0d", id, j, fmt_data_o, fmt_start_o, fmt_end_o);
      chk("send_data",   fmt_data_o,         exp_words[j]);
      chk("send_start",  32'(fmt_start_o),   32'(j == 0));
      chk("send_end",    32'(fmt_end_o),     32'(j == len - 1));
      chk("send_req",    32'(fmt_req_o),     32'd0);
      chk("send_child",  32'(fmt_child_o),   32'(id));
      chk("send_length", 32'(fmt_length_o),  32'(len));
      chk("send_ack",    32'(f2a_ack_o),     32'd0);
    end
    fmt_grant_i = 1'b0;
    step();
    check_idle_outputs("after_pkt");
    chk("after_pkt_ack", 32'(f2a_ack_o), 32'd1);
    wr_n = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    wr_n = 0;
    rst_i = 1'b1;
    a2f_val_i = 1'b0;
    a2f_id_i = 2'd0;
    a2f_data_i = 32'd0;
    a2f_pkglen_sel_i = 3'd0;
    a2f_end_i = 1'b0;
    fmt_grant_i = 1'b0;

    // Reset state
    step();
    step();
    check_idle_outputs("reset");
    chk("reset_ack", 32'(f2a_ack_o), 32'd1);
    rst_i = 1'b0;
    step();

    // Full packet, sel=0, id=2; sel changed mid-packet must not matter
    put_word(2'd2, 32'hA0, 3'd0, 1'b0);
    put_word(2'd2, 32'hA1, 3'd3, 1'b0);
    put_word(2'd2, 32'hA2, 3'd3, 1'b0);
    put_word(2'd2, 32'hA3, 3'd3, 1'b0);
    check_packet(2, 4, 1, 2);

    // Flush after 5 words with sel=2
    for (int i = 0; i < 5; i++) put_word(2'd1, 32'hB0 + 32'(i), 3'd2, i == 4);
    check_packet(1, 5, 1, 0);

    // Id switch: id=1 word waits while id=0 packet is open
    put_word(2'd0, 32'hC0, 3'd0, 1'b0);
    put_word(2'd0, 32'hC1, 3'd0, 1'b0);
    a2f_val_i = 1'b1;
    a2f_id_i = 2'd1;
    a2f_data_i = 32'hD0;
    #1;
    chk("idsw_ack0", 32'(f2a_ack_o), 32'd0);
    step();
    chk("idsw_ack1", 32'(f2a_ack_o), 32'd0);
    chk("idsw_req", 32'(fmt_req_o), 32'd0);
    a2f_end_i = 1'b1;
    step();
    a2f_end_i = 1'b0;
    a2f_val_i = 1'b0;
    check_packet(0, 2, 1, 0);
    put_word(2'd1, 32'hD0, 3'd0, 1'b0);
    put_word(2'd1, 32'hD1, 3'd0, 1'b0);
    put_word(2'd1, 32'hD2, 3'd0, 1'b0);
    put_word(2'd1, 32'hD3, 3'd0, 1'b0);
    check_packet(1, 4, 1, 0);

    // Grant and flush in IDLE are ignored
    fmt_grant_i = 1'b1;
    step();
    fmt_grant_i = 1'b0;
    check_idle_outputs("grant_idle");
    a2f_end_i = 1'b1;
    step();
    a2f_end_i = 1'b0;
    check_idle_outputs("end_idle");
    chk("end_idle_ack", 32'(f2a_ack_o), 32'd1);

    // Grant in FILL ignored; grant held 3 cycles in REQ gives one packet
    put_word(2'd3, 32'hE0, 3'd0, 1'b0);
    fmt_grant_i = 1'b1;
    step();
    fmt_grant_i = 1'b0;
    chk("grant_fill_req", 32'(fmt_req_o), 32'd0);
    chk("grant_fill_start", 32'(fmt_start_o), 32'd0);
    chk("grant_fill_ack", 32'(f2a_ack_o), 32'd1);
    put_word(2'd3, 32'hE1, 3'd0, 1'b0);
    put_word(2'd3, 32'hE2, 3'd0, 1'b0);
    put_word(2'd3, 32'hE3, 3'd0, 1'b0);
    check_packet(3, 4, 3, 0);
    step();
    check_idle_outputs("hold_idle1");
    step();
    check_idle_outputs("hold_idle2");

    // Reset in the middle of an 8-word packet
    for (int i = 0; i < 8; i++) put_word(2'd1, 32'hF0 + 32'(i), 3'd1, 1'b0);
    chk("rst_pkt_len", 32'(fmt_length_o), 32'd8);
    fmt_grant_i = 1'b1;
    step();
    fmt_grant_i = 1'b0;
    chk("rst_w0", fmt_data_o, 32'hF0);
    step();
    chk("rst_w1", fmt_data_o, 32'hF1);
    #2;
    rst_i = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    chk("async_rst_ack", 32'(f2a_ack_o), 32'd1);
    step();
    rst_i = 1'b0;
    wr_n = 0;
    step();
    check_idle_outputs("post_rst");
    put_word(2'd2, 32'h50, 3'd0, 1'b0);
    put_word(2'd2, 32'h51, 3'd0, 1'b0);
    put_word(2'd2, 32'h52, 3'd0, 1'b0);
    put_word(2'd2, 32'h53, 3'd0, 1'b0);
    check_packet(2, 4, 1, 1);

    // Max length via sel=5
    for (int i = 0; i < 32; i++) put_word(2'd3, $urandom, 3'd5, 1'b0);
    check_packet(3, 32, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcdf_formatter_p.md
Name: mcdf_formatter_p

Overview:
- Parametrised successor of the MCDF formatter.
- Takes words from the channel arbiter, buffers one packet per channel in a local buffer, and requests the downstream bus.
- On grant, streams the packet with start/end framing, channel id and length.
- Adds over the first-generation formatter:
  - configurable data width, channel count and maximum packet length;
  - an explicit valid/ack input handshake;
  - early flush of short packets via a2f_end_i.

Parameters:
- DW, 32, data width of a2f_data_i / fmt_data_o.
- CHN, 4, number of arbiter channels.
- IDW, 2, channel id width; CHN <= 2**IDW.
- MAXLEN, 32, maximum packet length in words; power of 2; sets packet buffer depth.
- LW, 6, length field width; must hold MAXLEN.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- a2f_val_i  in  1  arbiter word valid
- a2f_id_i  in  IDW  channel id of current word
- a2f_data_i  in  DW  data word
- a2f_pkglen_sel_i  in  3  packet length select
- a2f_end_i  in  1  flush request: close current packet early
- f2a_ack_o  out  1  formatter accepts word this cycle
- fmt_req_o  out  1  bus request, packet ready
- fmt_grant_i  in  1  bus grant, single-cycle pulse
- fmt_child_o  out  IDW  channel id of packet
- fmt_length_o  out  LW  packet length in words
- fmt_data_o  out  DW  packet data
- fmt_start_o  out  1  first word marker
- fmt_end_o  out  1  last word marker

Behaviour:
- Reset (async, immediate):
  - state=IDLE, word count=0, read/write pointers=0;
  - all outputs 0 except f2a_ack_o=1.
- Length decode of a2f_pkglen_sel_i:
  - 0→4, 1→8, 2→16, 3→32;
  - 4..7 → MAXLEN;
  - any decoded value above MAXLEN is clamped to MAXLEN.
- Input transfer occurs on a rising edge where a2f_val_i && f2a_ack_o.
- f2a_ack_o is 1 only in IDLE and FILL, and only while count < latched length.
- States:
  - IDLE: the first transfer latches pkt_id=a2f_id_i and pkt_len=decode(sel), writes the word, count=1, then goes to FILL. If pkt_len==1 it goes directly to REQ.
  - FILL: accepts only words with a2f_id_i==pkt_id. A word with a different id gets f2a_ack_o=0 (combinationally) and stays pending upstream. Leave FILL when count reaches pkt_len, or when a2f_end_i=1 with count>=1 (including a word accepted in the same cycle). On flush, pkt_len := count.
  - REQ: fmt_req_o=1. fmt_child_o=pkt_id and fmt_length_o=pkt_len are held stable until the packet ends. On an edge with fmt_grant_i=1, go to SEND.
  - SEND: fmt_req_o=0. One word per cycle for pkt_len cycles, in buffer order. fmt_start_o=1 on the first word only; fmt_end_o=1 on the last word only; both are 1 when pkt_len==1. The cycle after the last word: state=IDLE, count=0, and the framing, data, child and length outputs return to 0.
- Latency (full packet):
  - fmt_req_o rises on the edge after the last word is accepted;
  - the first output word appears on the edge after the grant;
  - a new transfer can be accepted 1 cycle after fmt_end_o.
- Boundary cases:
  - fmt_grant_i outside REQ: ignored.
  - a2f_end_i in IDLE with count 0: ignored; no zero-length packet.
  - a2f_end_i in REQ/SEND: ignored.
  - a2f_val_i while f2a_ack_o=0: no state change.
  - Changing a2f_pkglen_sel_i mid-packet has no effect; the length is latched in IDLE.
  - Reset during SEND aborts the packet; no fmt_end_o is generated.
- Outputs fmt_* and fmt_req_o are registered. f2a_ack_o may be combinational from state, count and a2f_id_i.
- No data reordering and no word loss or duplication. Output order equals accept order.

Test Plan:
- Full packet, sel=0, id=2:
  - stimulus: 4 consecutive valid words 0xA0..0xA3; grant pulsed 2 cycles after fmt_req_o;
  - required: fmt_length_o=4, fmt_child_o=2; data A0..A3 on 4 consecutive cycles; fmt_start_o with A0, fmt_end_o with A3; f2a_ack_o=0 from the 4th accept until 1 cycle after fmt_end_o.
- Flush, sel=2 (len 16):
  - stimulus: 5 words, with a2f_end_i asserted alongside the 5th word;
  - required: fmt_req_o=1 next edge; fmt_length_o=5; exactly 5 words out, end on the 5th.
- Id switch:
  - stimulus: 2 words on id=0, then valid with id=1;
  - required: f2a_ack_o=0 for id=1 while in FILL; the id=1 word is accepted only after the id=0 packet completes.
- Grant handling:
  - stimulus: fmt_grant_i pulsed in IDLE and FILL;
  - required: no output activity. A grant held 3 cycles in REQ produces exactly one packet.
- Reset mid-SEND:
  - stimulus: rst_i raised asynchronously (between clock edges) after the 2nd of 8 output words;
  - required: all fmt_* outputs =0 immediately; f2a_ack_o=1; the next packet after release is correct from word 0.
- Max length:
  - stimulus: sel=5 with MAXLEN=32; 32 random words;
  - required: fmt_length_o=32; scoreboard matches all 32 words in order.
